wrap_tick_timer: RTL and testbench

- Downstream consumer of the 4-bit free-running `counter` stage.
- Treats the counter's wrap indication (`cont` low) as a tick, one tick every 16 clocks.
- Counts ticks in a WIDTH-bit high-order counter against a programmable period.
- Emits expiry events through a valid/ready handshake, in one-shot or periodic mode, and keeps a saturating count of events dropped under backpressure.

---
 rtl/wrap_tick_timer_pkg.sv | 16 +
 rtl/wrap_tick_timer_event_slot.sv | 55 +++++
 rtl/wrap_tick_timer.sv | 105 ++++++++++
 tb/tb_wrap_tick_timer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wrap_tick_timer_pkg.sv
// wrap_tick_timer_pkg
// Shared types and default sizes for the wrap tick timer.
//   state_e         : timer FSM state (IDLE / RUN), one bit
//   DEF_WIDTH       : default width of the high-order tick counter and period
//   DEF_DROP_W      : default width of the saturating dropped-event counter
package wrap_tick_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DROP_W = 8;

endpackage

// File: rtl/wrap_tick_timer_event_slot.sv
// event_slot
// One-deep pending-event slot with a valid/ready output handshake and a
// saturating count of events lost while the slot was already occupied.
// Handshake: an event is transferred on every rising edge where
// valid & ready are both high; valid never drops without a transfer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   raise       : new event this cycle
//   ready       : consumer accepts the pending event
//   valid       : event pending (registered)
//   drop_count  : events lost to backpressure, saturating, cleared by reset only
module event_slot
    import wrap_tick_timer_pkg::*;
#(
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              raise,
    input  logic              ready,
    output logic              valid,
    output logic [DROP_W-1:0] drop_count
);

    logic              valid_d, valid_q;
    logic [DROP_W-1:0] drop_d, drop_q;

    always_comb begin
        valid_d = valid_q;
        drop_d  = drop_q;
        if (raise) begin
            // A new event either fills an empty slot, replaces one being
            // handed off this cycle, or is lost because the slot is stuck.
            valid_d = 1'b1;
            if (valid_q && !ready && (drop_q != {DROP_W{1'b1}})) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign valid      = valid_q;
    assign drop_count = drop_q;

endmodule

// File: rtl/wrap_tick_timer.sv
// wrap_tick_timer
// Counts wrap ticks of an upstream 4-bit free-running counter (tick when its
// cont output is low) against a programmable period and raises expiry
// events, one-shot or periodic, through a valid/ready event slot.
// Handshake: expire_valid stays high until a rising edge with
// expire_valid & expire_ready; expiries while it is still pending and not
// being accepted are counted in drop_count.
//   clk, rst_n    : clock, asynchronous active-low reset
//   low_cont      : upstream cont; tick = ~low_cont
//   start / stop  : single-cycle control pulses (stop wins)
//   period        : ticks per expiry, 0 means 2^WIDTH (sampled on start)
//   periodic      : 1 re-arms after expiry, 0 one-shot (sampled on start)
//   busy          : high while in RUN
//   high_count    : ticks since start or last expiry
//   expire_valid / expire_ready : expiry event handshake
//   drop_count    : saturating count of lost expiries
module wrap_tick_timer
    import wrap_tick_timer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              low_cont,
    input  logic              start,
    input  logic              stop,
    input  logic [WIDTH-1:0]  period,
    input  logic              periodic,
    output logic              busy,
    output logic [WIDTH-1:0]  high_count,
    output logic              expire_valid,
    input  logic              expire_ready,
    output logic [DROP_W-1:0] drop_count
);

    state_e             state_d, state_q;
    logic [WIDTH-1:0]   count_d, count_q;
    logic [WIDTH-1:0]   period_d, period_q;
    logic               periodic_d, periodic_q;
    logic               tick;
    logic               expire;
    logic [WIDTH-1:0]   last_count;

    assign tick = ~low_cont;
    // period_q == 0 wraps to all-ones here, giving 2^WIDTH ticks per expiry.
    assign last_count = period_q - WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        expire     = 1'b0;
        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            // Restart even from RUN; a tick in this cycle is deliberately lost.
            state_d    = RUN;
            period_d   = period;
            periodic_d = periodic;
            count_d    = '0;
        end else if (state_q == RUN && tick) begin
            if (count_q == last_count) begin
                expire  = 1'b1;
                count_d = '0;
                if (!periodic_q) begin
                    state_d = IDLE;
                end
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
        end
    end

    event_slot #(
        .DROP_W(DROP_W)
    ) u_event_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .raise      (expire),
        .ready      (expire_ready),
        .valid      (expire_valid),
        .drop_count (drop_count)
    );

    assign busy       = (state_q == RUN);
    assign high_count = count_q;

endmodule

// File: tb/tb_wrap_tick_timer.sv
module tb_wrap_tick_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       low_cont = 1'b1;

    // main instance, default sizes
    logic       start = 1'b0, stop = 1'b0, periodic = 1'b0, ready = 1'b1;
    logic [7:0] period = 8'd0;
    logic       busy, valid;
    logic [7:0] hc, drop;

    // narrow instance, WIDTH=4 DROP_W=2
    logic       start4 = 1'b0, stop4 = 1'b0, periodic4 = 1'b0, ready4 = 1'b1;
    logic [3:0] period4 = 4'd0;
    logic       busy4, valid4;
    logic [3:0] hc4;
    logic [1:0] drop4;

    logic [3:0] lc_cnt;
    int         n_cmp = 0;
    int         n_err = 0;

    wrap_tick_timer u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .low_cont     (low_cont),
        .start        (start),
        .stop         (stop),
        .period       (period),
        .periodic     (periodic),
        .busy         (busy),
        .high_count   (hc),
        .expire_valid (valid),
        .expire_ready (ready),
        .drop_count   (drop)
    );

    wrap_tick_timer #(.WIDTH(4), .DROP_W(2)) u_dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .low_cont     (low_cont),
        .start        (start4),
        .stop         (stop4),
        .period       (period4),
        .periodic     (periodic4),
        .busy         (busy4),
        .high_count   (hc4),
        .expire_valid (valid4),
        .expire_ready (ready4),
        .drop_count   (drop4)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one clock with or without a tick; control pulses last one cycle
    task automatic step(input logic t);
        low_cont = ~t;
        @(posedge clk);
        #1;
        low_cont = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        start4   = 1'b0;
        stop4    = 1'b0;
    endtask

    // free-running upstream counter: cont low while it sits at 15
    task automatic run_free(input int n);
        for (int i = 0; i < n; i++) begin
            low_cont = (lc_cnt != 4'd15);
            @(posedge clk);
            #1;
            lc_cnt++;
        end
        low_cont = 1'b1;
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_hc", hc, 0);
        check("rst_valid", valid, 0);
        check("rst_drop", drop, 0);
        rst_n = 1'b1;
        step(1);
        check("idle_tick_ignored", hc, 0);

        // periodic, period=3, ready=1
        start = 1; period = 8'd3; periodic = 1;
        step(0);
        check("p3_busy", busy, 1);
        check("p3_hc0", hc, 0);
        step(1);
        check("p3_hc1", hc, 1);
        step(0);
        check("p3_hc1_hold", hc, 1);
        step(1);
        check("p3_hc2", hc, 2);
        check("p3_novalid", valid, 0);
        step(1);
        check("p3_hc_wrap", hc, 0);
        check("p3_valid", valid, 1);
        check("p3_busy_after", busy, 1);
        step(0);
        check("p3_valid_clr", valid, 0);
        step(1); step(1); step(1);
        check("p3_valid2", valid, 1);
        stop = 1;
        step(0);
        check("stop_busy", busy, 0);
        check("stop_hc", hc, 0);

        // one-shot, period=2
        start = 1; period = 8'd2; periodic = 0;
        step(0);
        step(1);
        check("os_hc1", hc, 1);
        check("os_busy", busy, 1);
        step(1);
        check("os_busy_fall", busy, 0);
        check("os_valid", valid, 1);
        check("os_hc0", hc, 0);
        step(1);
        check("os_after_hc", hc, 0);
        check("os_after_valid", valid, 0);

        // start+stop together, start on a tick
        start = 1; stop = 1; period = 8'd5; periodic = 1;
        step(0);
        check("startstop_busy", busy, 0);
        start = 1;
        step(0);
        step(1); step(1);
        check("pre_restart_hc", hc, 2);
        start = 1;
        step(1);
        check("restart_on_tick_hc", hc, 0);
        check("restart_busy", busy, 1);
        step(1);
        check("restart_hc1", hc, 1);
        stop = 1;
        step(0);

        // backpressure, period=1, ready=0
        ready = 0; start = 1; period = 8'd1; periodic = 1;
        step(0);
        step(1);
        check("bp_valid1", valid, 1);
        check("bp_drop0", drop, 0);
        repeat (4) step(1);
        check("bp_valid5", valid, 1);
        check("bp_drop4", drop, 4);
        ready = 1;
        step(1);
        check("sim_ready_valid", valid, 1);
        check("sim_ready_drop", drop, 4);
        step(0);
        check("bp_drain_valid", valid, 0);
        check("bp_drop_kept", drop, 4);
        stop = 1;
        step(0);

        // saturation on the narrow instance
        ready4 = 0; start4 = 1; period4 = 4'd1; periodic4 = 1;
        step(0);
        repeat (3) step(1);
        check("sat_drop2", drop4, 2);
        repeat (3) step(1);
        check("sat_drop3", drop4, 3);
        check("sat_valid", valid4, 1);
        ready4 = 1; stop4 = 1;
        step(0);
        check("sat_drain", valid4, 0);

        // period=0 on WIDTH=4: 16 ticks, 256 clocks
        start4 = 1; period4 = 4'd0; periodic4 = 0;
        step(0);
        lc_cnt = 4'd0;
        run_free(255);
        check("p0_hc15", hc4, 15);
        check("p0_novalid", valid4, 0);
        check("p0_busy", busy4, 1);
        run_free(1);
        check("p0_valid", valid4, 1);
        check("p0_busy_fall", busy4, 0);
        check("p0_hc0", hc4, 0);

        // reset mid-RUN with hc=5 and an event pending
        ready = 0; start = 1; period = 8'd6; periodic = 1;
        step(0);
        repeat (6) step(1);
        repeat (5) step(1);
        check("mid_hc5", hc, 5);
        check("mid_valid", valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_hc", hc, 0);
        check("async_valid", valid, 0);
        check("async_drop", drop, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
